dcro_freq_tracker: RTL and testbench



---
 rtl/dcro_freq_tracker.sv | 184 ++++++++++++++++++
 tb/tb_dcro_freq_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcro_freq_tracker.sv
// rtl/dcro_freq_tracker.sv - DCRO frequency tracking loop: windowed edge count, proportional incremental correction, lock detect
module dcro_freq_tracker #(
   parameter int sel_len    = 8,
   parameter int CNT_W      = 16,
   parameter int GATE_LEN   = 1024,
   parameter int SETTLE_LEN = 16,
   parameter int SHIFT      = 2,
   parameter int MAX_STEP   = 16,
   parameter int TOL        = 1,
   parameter int LOCK_N     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               osc_in,
   input  logic [CNT_W-1:0]   target_cnt,
   input  logic [sel_len-1:0] init_word,
   output logic               mode,
   output logic [sel_len:0]   sel_cmd,
   output logic               cmd_valid,
   output logic [CNT_W-1:0]   meas_cnt,
   output logic               locked
);

   localparam int GATE_W = $clog2(GATE_LEN + 1);
   localparam int SET_W  = $clog2(SETTLE_LEN + 1);
   localparam int LOCK_W = $clog2(LOCK_N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_MEASURE,
      S_COMPARE,
      S_ISSUE,
      S_SETTLE
   } state_t;

   state_t state, state_nx;

   logic                 osc_s1, osc_s2, osc_s3;
   logic                 osc_edge;
   logic [GATE_W-1:0]    gate_cnt;
   logic [SET_W-1:0]     settle_cnt;
   logic [CNT_W-1:0]     edge_cnt;
   logic [LOCK_W-1:0]    lock_cnt;
   logic                 gate_done, settle_done;

   logic signed [CNT_W:0] err;
   logic [CNT_W:0]        err_mag, err_shr, step_mag;
   logic                  in_tol;
   logic [sel_len:0]      step;

   logic                  mode_nx, valid_nx;
   logic [sel_len:0]      sel_nx;

   // Two synchronizer flops, the third holds the previous sample for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         osc_s1 <= 1'b0;
         osc_s2 <= 1'b0;
         osc_s3 <= 1'b0;
      end else begin
         osc_s1 <= osc_in;
         osc_s2 <= osc_s1;
         osc_s3 <= osc_s2;
      end
   end

   assign osc_edge    = osc_s2 & ~osc_s3;
   assign gate_done   = (gate_cnt == GATE_W'(GATE_LEN - 1));
   assign settle_done = (settle_cnt == SET_W'(SETTLE_LEN - 1));

   // Step is derived from the live edge count so it is ready during COMPARE.
   always_comb begin
      err     = $signed({1'b0, target_cnt}) - $signed({1'b0, edge_cnt});
      err_mag = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
      err_shr = err_mag >> SHIFT;
      in_tol  = (err_mag <= (CNT_W+1)'(TOL));
      if (err_shr == '0)
         step_mag = (CNT_W+1)'(1);
      else if (err_shr > (CNT_W+1)'(MAX_STEP))
         step_mag = (CNT_W+1)'(MAX_STEP);
      else
         step_mag = err_shr;
      if (in_tol)
         step = '0;
      else if (err[CNT_W])
         step = -(sel_len+1)'(step_mag);
      else
         step = (sel_len+1)'(step_mag);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (enable) state_nx = S_INIT;
         S_INIT:    state_nx = S_SETTLE;
         S_SETTLE:  if (settle_done) state_nx = S_MEASURE;
         S_MEASURE: if (gate_done) state_nx = S_COMPARE;
         S_COMPARE: state_nx = S_ISSUE;
         S_ISSUE:   state_nx = S_SETTLE;
         default:   state_nx = S_IDLE;
      endcase
      if (!enable)
         state_nx = S_IDLE;

      // Outputs are registered from the next state so they line up with the state register.
      mode_nx  = 1'b1;
      sel_nx   = '0;
      valid_nx = 1'b0;
      case (state_nx)
         S_IDLE: begin
            mode_nx = 1'b0;
            sel_nx  = {1'b0, init_word};
         end
         S_INIT: begin
            mode_nx  = 1'b0;
            sel_nx   = {1'b0, init_word};
            valid_nx = 1'b1;
         end
         S_ISSUE: begin
            sel_nx   = step;
            valid_nx = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mode       <= 1'b0;
         sel_cmd    <= '0;
         cmd_valid  <= 1'b0;
         gate_cnt   <= '0;
         settle_cnt <= '0;
         edge_cnt   <= '0;
         lock_cnt   <= '0;
         meas_cnt   <= '0;
         locked     <= 1'b0;
      end else begin
         state     <= state_nx;
         mode      <= mode_nx;
         sel_cmd   <= sel_nx;
         cmd_valid <= valid_nx;
         if (!enable) begin
            gate_cnt   <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
         end else begin
            case (state)
               S_INIT, S_ISSUE: settle_cnt <= '0;
               S_SETTLE: begin
                  settle_cnt <= settle_cnt + 1'b1;
                  if (settle_done) begin
                     gate_cnt <= '0;
                     edge_cnt <= '0;
                  end
               end
               S_MEASURE: begin
                  gate_cnt <= gate_cnt + 1'b1;
                  if (osc_edge && edge_cnt != '1)
                     edge_cnt <= edge_cnt + 1'b1;
               end
               S_COMPARE: begin
                  meas_cnt <= edge_cnt;
                  if (in_tol) begin
                     if (lock_cnt != LOCK_W'(LOCK_N))
                        lock_cnt <= lock_cnt + 1'b1;
                     locked <= (lock_cnt >= LOCK_W'(LOCK_N - 1));
                  end else begin
                     lock_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dcro_freq_tracker.sv
// tb/tb_dcro_freq_tracker.sv - randomized self-checking bench for dcro_freq_tracker
module tb_dcro_freq_tracker;

   localparam int SEL_LEN    = 8;
   localparam int CNT_W      = 16;
   localparam int GATE_LEN   = 64;
   localparam int SETTLE_LEN = 16;
   localparam int SHIFT      = 2;
   localparam int MAX_STEP   = 16;
   localparam int TOL        = 1;
   localparam int LOCK_N     = 3;
   localparam int CMD_GAP    = SETTLE_LEN + GATE_LEN + 2;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               enable = 1'b0;
   logic               osc_in = 1'b0;
   logic [CNT_W-1:0]   target_cnt = '0;
   logic [SEL_LEN-1:0] init_word = '0;
   logic               mode;
   logic [SEL_LEN:0]   sel_cmd;
   logic               cmd_valid;
   logic [CNT_W-1:0]   meas_cnt;
   logic               locked;

   int n_checks = 0;
   int n_fail   = 0;
   int osc_per  = 4;
   int osc_ph   = 0;
   int mdl_lock = 0;
   int mdl_meas = 0;
   int cur_iw   = 0;
   int periods[4] = '{4, 8, 16, 32};

   dcro_freq_tracker #(
      .sel_len(SEL_LEN), .CNT_W(CNT_W), .GATE_LEN(GATE_LEN), .SETTLE_LEN(SETTLE_LEN),
      .SHIFT(SHIFT), .MAX_STEP(MAX_STEP), .TOL(TOL), .LOCK_N(LOCK_N)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .osc_in(osc_in),
      .target_cnt(target_cnt), .init_word(init_word),
      .mode(mode), .sel_cmd(sel_cmd), .cmd_valid(cmd_valid),
      .meas_cnt(meas_cnt), .locked(locked)
   );

   always #5 clk = ~clk;

   // Oscillator with a whole number of clk periods, offset from the clock edge.
   always @(posedge clk) begin
      #3;
      osc_ph = (osc_ph + 1) % osc_per;
      osc_in = (osc_ph < osc_per / 2);
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_step(input int tgt, input int cnt);
      int e, m;
      e = tgt - cnt;
      m = (e < 0) ? -e : e;
      if (m <= TOL) return 0;
      m = m / (2 ** SHIFT);
      if (m < 1) m = 1;
      if (m > MAX_STEP) m = MAX_STEP;
      return (e < 0) ? -m : m;
   endfunction

   task automatic set_osc(input int p);
      osc_per = p;
      osc_ph  = 0;
   endtask

   task automatic wait_cmd(input string tag, input int limit, output int waited);
      waited = 0;
      while (cmd_valid !== 1'b1 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
      if (cmd_valid !== 1'b1)
         check({tag, "_timeout"}, cmd_valid, 1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      enable = 1'b0;
      #1;
      check({tag, "_mode"}, mode, 0);
      check({tag, "_sel"}, $signed(sel_cmd), 0);
      check({tag, "_valid"}, cmd_valid, 0);
      check({tag, "_meas"}, meas_cnt, 0);
      check({tag, "_locked"}, locked, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mdl_lock = 0;
      mdl_meas = 0;
   endtask

   task automatic start_loop(input int iw, input string tag);
      int w;
      cur_iw = iw;
      init_word = SEL_LEN'(iw);
      enable = 1'b1;
      mdl_lock = 0;
      wait_cmd(tag, 4, w);
      check({tag, "_lat"}, w, 1);
      check({tag, "_mode"}, mode, 0);
      check({tag, "_sel"}, $signed(sel_cmd), iw);
   endtask

   // Called on the negedge of a command cycle; checks the next ISSUE against the model.
   task automatic run_window(input int tgt, input string tag);
      int w, cnt, stp, e;
      target_cnt = CNT_W'(tgt);
      cnt = GATE_LEN / osc_per;
      stp = model_step(tgt, cnt);
      e = tgt - cnt;
      if (e <= TOL && e >= -TOL)
         mdl_lock = (mdl_lock < LOCK_N) ? mdl_lock + 1 : LOCK_N;
      else
         mdl_lock = 0;
      mdl_meas = cnt;
      @(negedge clk);
      check({tag, "_idle_mode"}, mode, 1);
      check({tag, "_idle_sel"}, $signed(sel_cmd), 0);
      check({tag, "_idle_valid"}, cmd_valid, 0);
      wait_cmd(tag, CMD_GAP + 8, w);
      check({tag, "_gap"}, w + 1, CMD_GAP);
      check({tag, "_mode"}, mode, 1);
      check({tag, "_step"}, $signed(sel_cmd), stp);
      check({tag, "_meas"}, meas_cnt, cnt);
      check({tag, "_locked"}, locked, (mdl_lock == LOCK_N) ? 1 : 0);
   endtask

   task automatic check_disabled(input string tag, input int span);
      int pulses;
      check({tag, "_mode"}, mode, 0);
      check({tag, "_sel"}, $signed(sel_cmd), cur_iw);
      check({tag, "_valid"}, cmd_valid, 0);
      check({tag, "_locked"}, locked, 0);
      pulses = 0;
      for (int i = 0; i < span; i++) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0) pulses++;
      end
      check({tag, "_no_cmd"}, pulses, 0);
      check({tag, "_meas_held"}, meas_cnt, mdl_meas);
      mdl_lock = 0;
   endtask

   // Called on the negedge of a command cycle; offset selects the cycle where enable drops.
   task automatic drop_enable(input int offset, input int new_per, input string tag);
      set_osc(new_per);
      repeat (offset) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check_disabled(tag, CMD_GAP + 10);
   endtask

   initial begin
      int iw, tgt, cnt;
      do_reset("por");

      set_osc(4);
      start_loop(100, "init");
      run_window(40, "t40");
      run_window(500, "t500");
      run_window(0, "t0");
      run_window(17, "lock1");
      run_window(17, "lock2");
      run_window(17, "lock3");
      run_window(30, "unlock");
      drop_enable(40, 4, "mid_meas");

      start_loop(77, "reinit");
      run_window(16, "pre_edge");
      drop_enable(GATE_LEN + SETTLE_LEN, 8, "win_end");

      set_osc(4);
      start_loop(200, "pre_rst");
      run_window(20, "pre_rst_w");
      repeat (5) @(negedge clk);
      do_reset("mid_settle");
      start_loop(100, "post_rst");
      run_window(40, "post_rst_w");

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 6; k++) begin
            set_osc(periods[$urandom_range(0, 3)]);
            cnt = GATE_LEN / osc_per;
            if ($urandom_range(0, 1) == 1)
               tgt = cnt + int'($urandom_range(0, 4)) - 2;
            else
               tgt = int'($urandom_range(0, 700));
            run_window(tgt, "rnd");
         end
         iw = int'($urandom_range(0, 255));
         if (r == 1) begin
            repeat (3) @(negedge clk);
            do_reset("rnd_rst");
         end else begin
            drop_enable(int'($urandom_range(20, 70)), periods[$urandom_range(0, 3)], "rnd_drop");
         end
         set_osc(periods[$urandom_range(0, 3)]);
         start_loop(iw, "rnd_init");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
